vector_output_drain: RTL and testbench

- Receiving end of the CPU output port. Captures each packed output vector qualified by the output flag into a small FIFO.
- Drains the FIFO one lane (byte) at a time over a valid/ready byte stream toward the host-side link (UART/JTAG bridge).
- Sits between the CPU top level and the board-level output logic, in the same clock domain as the CPU.

---
 rtl/vector_output_drain_pkg.sv | 24 ++
 rtl/vector_output_drain_if.sv | 39 +++
 rtl/vector_output_drain_fifo.sv | 67 ++++++
 rtl/vector_output_drain.sv | 144 ++++++++++++++
 tb/tb_vector_output_drain.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/vector_output_drain_pkg.sv
// Shared types and helpers for the CPU output drain path.
package cpu_out_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_t;

  localparam int DEF_VECTOR_SIZE  = 8;
  localparam int DEF_OUTPUT_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_PTR_WIDTH    = 2;
  localparam int DEF_IDX_W        = $clog2(DEF_VECTOR_SIZE);
  localparam int DEF_VEC_BITS     = DEF_VECTOR_SIZE * DEF_OUTPUT_WIDTH;

  // Lane idx of a packed vector; lane 0 lives in the least significant bits.
  function automatic logic [DEF_OUTPUT_WIDTH-1:0] lane_of(
    input logic [DEF_VEC_BITS-1:0] vec,
    input logic [DEF_IDX_W-1:0]    idx
  );
    return vec[idx*DEF_OUTPUT_WIDTH +: DEF_OUTPUT_WIDTH];
  endfunction

endpackage

// File: rtl/vector_output_drain_if.sv
// Bus between the CPU output port / host byte link and the drain block.
// OUT_DROP_COUNTER_EN adds the dropCount status signal.
interface vector_output_drain_if #(
  parameter int VECTOR_SIZE  = 8,
  parameter int OUTPUT_WIDTH = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int PTR_WIDTH    = 2
);
  logic [VECTOR_SIZE*OUTPUT_WIDTH-1:0] vecIn;
  logic                                vecValid;
  logic [OUTPUT_WIDTH-1:0]             byteOut;
  logic                                byteValid;
  logic                                byteReady;
  logic                                lastByte;
  logic [PTR_WIDTH:0]                  fifoCount;
  logic                                overflow;
  logic                                busy;
`ifdef OUT_DROP_COUNTER_EN
  logic [7:0]                          dropCount;
`endif

  // CPU side and byte sink, as seen from outside the drain
  modport master (
    output vecIn, vecValid, byteReady,
    input  byteOut, byteValid, lastByte, fifoCount, overflow, busy
`ifdef OUT_DROP_COUNTER_EN
    , input dropCount
`endif
  );

  // The drain block itself
  modport slave (
    input  vecIn, vecValid, byteReady,
    output byteOut, byteValid, lastByte, fifoCount, overflow, busy
`ifdef OUT_DROP_COUNTER_EN
    , output dropCount
`endif
  );
endinterface

// File: rtl/vector_output_drain_fifo.sv
// Vector FIFO feeding the lane shifter. A push is accepted while full as
// long as a pop happens on the same edge (the head slot is freed and reused).
module out_vector_fifo
  import cpu_out_pkg::*;
#(
  parameter int WIDTH = DEF_VEC_BITS,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int PW    = DEF_PTR_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH = 2**PW)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array, no reset needed: contents are only read behind count
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer/count registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vector_output_drain.sv
// Receives packed output vectors from the CPU, buffers them, and streams
// them out lane by lane (lane 0 first) over a valid/ready byte link.
// OUT_DROP_COUNTER_EN adds a saturating 8-bit dropped-vector counter.
module vector_output_drain
  import cpu_out_pkg::*;
#(
  parameter int VECTOR_SIZE  = DEF_VECTOR_SIZE,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int PTR_WIDTH    = DEF_PTR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  vector_output_drain_if.slave  bus
);

  localparam int VW = VECTOR_SIZE * OUTPUT_WIDTH;
  localparam int IW = $clog2(VECTOR_SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(VECTOR_SIZE - 1);

  drain_state_t            state_q, state_d;
  logic [VW-1:0]           shift_q, shift_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    overflow_q, overflow_d;
  logic                    pop, push_ok, drop;
  logic                    hs, at_last;
  logic [VW-1:0]           fifo_rdata;
  logic                    fifo_full, fifo_empty;
  logic [PTR_WIDTH:0]      fifo_count;
  logic [OUTPUT_WIDTH-1:0] lane_w;

  assign hs      = (state_q == SEND) && bus.byteReady;
  assign at_last = (idx_q == LAST_IDX);

  // Capture when there is room, or when the head leaves on this same edge
  assign push_ok = bus.vecValid && (!fifo_full || pop);
  assign drop    = bus.vecValid && !push_ok;

  out_vector_fifo #(
    .WIDTH (VW),
    .DEPTH (FIFO_DEPTH),
    .PW    (PTR_WIDTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (push_ok),
    .pop_i   (pop),
    .wdata_i (bus.vecIn),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  generate
    if (VECTOR_SIZE == DEF_VECTOR_SIZE && OUTPUT_WIDTH == DEF_OUTPUT_WIDTH) begin : g_lane_pkg
      assign lane_w = lane_of(shift_q, idx_q);
    end else begin : g_lane_gen
      assign lane_w = shift_q[idx_q*OUTPUT_WIDTH +: OUTPUT_WIDTH];
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and pop decision; reloading on the last handshake avoids a bubble
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs && at_last) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; byteOut is forced to zero outside SEND
  always_comb begin
    bus.byteValid = (state_q == SEND);
    bus.byteOut   = (state_q == SEND) ? lane_w : '0;
    bus.lastByte  = (state_q == SEND) && at_last;
    bus.busy      = (state_q == SEND) || !fifo_empty;
    bus.fifoCount = fifo_count;
    bus.overflow  = overflow_q;
  end

  // Shift register / lane index next-state
  always_comb begin
    shift_d    = shift_q;
    idx_d      = idx_q;
    overflow_d = overflow_q | drop;
    if (pop) begin
      shift_d = fifo_rdata;
      idx_d   = '0;
    end else if (hs) begin
      idx_d = at_last ? '0 : idx_q + IW'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef OUT_DROP_COUNTER_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped vectors
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Drop counter register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign bus.dropCount = drop_cnt_q;
`endif

endmodule

// File: tb/tb_vector_output_drain.sv
// Directed bench for vector_output_drain. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_vector_output_drain;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   lasts;
  int   ord [5] = '{1, 2, 3, 4, 6};

  always #5 clock = ~clock;

  vector_output_drain_if #(
    .VECTOR_SIZE(8), .OUTPUT_WIDTH(8), .FIFO_DEPTH(4), .PTR_WIDTH(2)
  ) bus ();

  vector_output_drain #(
    .VECTOR_SIZE(8), .OUTPUT_WIDTH(8), .FIFO_DEPTH(4), .PTR_WIDTH(2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Lane j of test vector k
  function automatic logic [7:0] byte_of(input int k, input int j);
    return 8'(k * 16 + j + 1);
  endfunction

  function automatic logic [63:0] mkvec(input int k);
    logic [63:0] v;
    for (int j = 0; j < 8; j++) v[j*8 +: 8] = byte_of(k, j);
    return v;
  endfunction

  task automatic do_reset();
    reset         = 1'b0;
    bus.vecValid  = 1'b0;
    bus.vecIn     = '0;
    bus.byteReady = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state
    do_reset();
    chk("rst_byteValid", bus.byteValid, 0);
    chk("rst_byteOut",   bus.byteOut,   0);
    chk("rst_lastByte",  bus.lastByte,  0);
    chk("rst_fifoCount", bus.fifoCount, 0);
    chk("rst_overflow",  bus.overflow,  0);
    chk("rst_busy",      bus.busy,      0);
`ifdef OUT_DROP_COUNTER_EN
    chk("rst_dropCount", bus.dropCount, 0);
`endif

    // ---- single vector, latency n+2, bytes 01..08
    bus.vecIn     = 64'h0807060504030201;
    bus.vecValid  = 1'b1;
    bus.byteReady = 1'b1;
    tick();
    bus.vecValid = 1'b0;
    chk("single_cnt_n1",   bus.fifoCount, 1);
    chk("single_bv_n1",    bus.byteValid, 0);
    chk("single_busy_n1",  bus.busy,      1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("single_bv",   bus.byteValid, 1);
      chk("single_byte", bus.byteOut,   64'(i + 1));
      chk("single_last", bus.lastByte,  (i == 7) ? 1 : 0);
    end
    tick();
    chk("single_bv_end",   bus.byteValid, 0);
    chk("single_busy_end", bus.busy,      0);

    // ---- backpressure, ready toggling 1,0,1,0...
    bus.byteReady = 1'b0;
    bus.vecValid  = 1'b1;
    tick();
    bus.vecValid = 1'b0;
    tick();
    for (int k = 0; k < 15; k++) begin
      bus.byteReady = (k % 2 == 0);
      chk("bp_bv",   bus.byteValid, 1);
      chk("bp_byte", bus.byteOut,   64'((k + 1) / 2 + 1));
      chk("bp_last", bus.lastByte,  ((k + 1) / 2 == 7) ? 1 : 0);
      tick();
    end
    chk("bp_bv_end", bus.byteValid, 0);
    bus.byteReady = 1'b0;

    // ---- overflow: six vectors, ready low, V5 dropped
    do_reset();
    for (int k = 0; k < 6; k++) begin
      bus.vecIn    = mkvec(k);
      bus.vecValid = 1'b1;
      tick();
    end
    bus.vecValid = 1'b0;
    chk("ovf_count", bus.fifoCount, 4);
    chk("ovf_flag",  bus.overflow,  1);
    chk("ovf_bv",    bus.byteValid, 1);
    chk("ovf_hold",  bus.byteOut,   byte_of(0, 0));
`ifdef OUT_DROP_COUNTER_EN
    chk("ovf_drop1", bus.dropCount, 1);
`endif
    bus.byteReady = 1'b1;
    lasts = 0;
    for (int b = 0; b < 40; b++) begin
      chk("ovf_stream_bv",   bus.byteValid, 1);
      chk("ovf_stream_byte", bus.byteOut,   byte_of(b / 8, b % 8));
      if (bus.lastByte) lasts++;
      tick();
    end
    chk("ovf_bv_end",  bus.byteValid, 0);
    chk("ovf_lasts",   64'(lasts),    5);
    chk("ovf_sticky",  bus.overflow,  1);
    chk("ovf_busy",    bus.busy,      0);

    // ---- full FIFO with push on the last-byte handshake
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus.vecIn    = mkvec(k);
      bus.vecValid = 1'b1;
      tick();
    end
    bus.vecValid = 1'b0;
    chk("wtf_count0", bus.fifoCount, 4);
    bus.byteReady = 1'b1;
    repeat (7) tick();
    chk("wtf_last",   bus.lastByte,  1);
    chk("wtf_count1", bus.fifoCount, 4);
    bus.vecIn    = mkvec(6);
    bus.vecValid = 1'b1;
    tick();
    bus.vecValid = 1'b0;
    chk("wtf_count2", bus.fifoCount, 4);
    chk("wtf_ovf",    bus.overflow,  0);
    for (int b = 0; b < 40; b++) begin
      chk("wtf_byte", bus.byteOut, byte_of(ord[b / 8], b % 8));
      tick();
    end
    chk("wtf_bv_end", bus.byteValid, 0);
    chk("wtf_ovf_end", bus.overflow, 0);

    // ---- reset after the 3rd handshake
    do_reset();
    bus.byteReady = 1'b1;
    bus.vecIn     = mkvec(0);
    bus.vecValid  = 1'b1;
    tick();
    bus.vecIn = mkvec(1);
    tick();
    bus.vecIn = mkvec(2);
    tick();
    bus.vecValid = 1'b0;
    tick();
    tick();
    chk("mid_byte",  bus.byteOut,   byte_of(0, 3));
    chk("mid_count", bus.fifoCount, 2);
    reset = 1'b0;
    #1;
    chk("mid_rst_bv",    bus.byteValid, 0);
    chk("mid_rst_count", bus.fifoCount, 0);
    chk("mid_rst_busy",  bus.busy,      0);
    chk("mid_rst_byte",  bus.byteOut,   0);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("post_rst_bv", bus.byteValid, 0);
    end

`ifdef OUT_DROP_COUNTER_EN
    // ---- drop counter saturation: 5 accepted, 300 dropped
    do_reset();
    chk("drop_rst", bus.dropCount, 0);
    bus.vecIn    = mkvec(3);
    bus.vecValid = 1'b1;
    repeat (305) tick();
    bus.vecValid = 1'b0;
    chk("drop_sat", bus.dropCount, 255);
    chk("drop_ovf", bus.overflow,  1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
